vend_sched: RTL and testbench

Request scheduler and sequencer in front of the coin-operated vending state machine. It turns raw level inputs (nickel, dime, item1, item2, push/refund) into single-cycle, mutually exclusive command pulses, arbitrating simultaneous requests by fixed priority. It also tracks credit in 5-cent units, rejects illegal coins and purchases, holds dispense outputs for a programmable time, and paces nickel change pulses during a refund. Inputs are already synchronous to `clk`.

---
 rtl/vend_sched.sv | 215 +++++++++++++++++++++
 tb/tb_vend_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vend_sched.sv
`default_nettype none
// ============================================================================
// Module   : vend_sched
// Purpose  : Request scheduler / sequencer in front of the coin-operated vend
//            FSM. Edge-detects raw level requests, keeps one pending flag per
//            request, grants one request per idle cycle by fixed priority
//            (push > item1 > item2 > dime > nickel), tracks credit in 5c
//            units, rejects illegal coins/purchases, holds dispense drives
//            and paces nickel change pulses during a refund.
// Ports    : clk, rst (sync, active-high)
//            n_in, d_in, item1_req, item2_req, push_req : raw request levels
//            n_pulse, d_pulse, item1_pulse, item2_pulse, push_pulse :
//                one-cycle, mutually exclusive commands
//            credit[1:0]          : credit in 5c units (0..3)
//            dispense1, dispense2 : dispense drives, DISP_CYCLES long
//            change_nickel        : one pulse per returned nickel
//            coin_rej, item_deny  : one-cycle reject / deny pulses
//            busy                 : FSM not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module vend_sched #(
  parameter int DISP_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       n_in,
  input  logic       d_in,
  input  logic       item1_req,
  input  logic       item2_req,
  input  logic       push_req,
  output logic       n_pulse,
  output logic       d_pulse,
  output logic       item1_pulse,
  output logic       item2_pulse,
  output logic       push_pulse,
  output logic [1:0] credit,
  output logic       dispense1,
  output logic       dispense2,
  output logic       change_nickel,
  output logic       coin_rej,
  output logic       item_deny,
  output logic       busy
);

  localparam int CMAX = (DISP_CYCLES > GAP_CYCLES) ? DISP_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  // Request vector bit positions (also the priority order, high to low)
  localparam int c_PUSH  = 4;
  localparam int c_ITEM1 = 3;
  localparam int c_ITEM2 = 2;
  localparam int c_DIME  = 1;
  localparam int c_NICK  = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DISP   = 2'd1,
    S_REFUND = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [1:0]      r_nick, w_nick_nx;
  logic [1:0]      r_credit, w_credit_nx;
  logic            r_sel2, w_sel2_nx;
  logic [4:0]      r_prev, r_pend, w_pend_nx, w_clr, w_rise, w_in;
  logic [4:0]      r_cmd, w_cmd_nx;
  logic            r_chg, w_chg_nx;
  logic            r_rej, w_rej_nx;
  logic            r_deny, w_deny_nx;
  logic            w_arb;

  assign w_in   = {push_req, item1_req, item2_req, d_in, n_in};
  assign w_rise = w_in & ~r_prev;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_nick_nx   = r_nick;
    w_credit_nx = r_credit;
    w_sel2_nx   = r_sel2;
    w_clr       = '0;
    w_cmd_nx    = '0;
    w_chg_nx    = 1'b0;
    w_rej_nx    = 1'b0;
    w_deny_nx   = 1'b0;
    w_arb       = 1'b0;

    case (r_state)
      S_IDLE: w_arb = 1'b1;
      S_DISP: begin
        // Last dispense cycle: the FSM is IDLE from the next edge on, so a
        // grant may be registered on that same edge.
        if (r_cnt <= CW'(1)) begin
          w_state_nx = S_IDLE;
          w_arb      = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_REFUND: begin
        // r_cnt counts the low gap; at zero either emit the next nickel or,
        // with none left, leave (the trailing gap has then elapsed).
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CW'(1);
        end else if (r_nick != 2'd0) begin
          w_chg_nx  = 1'b1;
          w_nick_nx = r_nick - 2'd1;
          w_cnt_nx  = CW'(GAP_CYCLES);
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_arb) begin
      if (r_pend[c_PUSH]) begin
        w_clr[c_PUSH]    = 1'b1;
        w_cmd_nx[c_PUSH] = 1'b1;
        w_credit_nx      = 2'd0;
        if (r_credit != 2'd0) begin
          w_state_nx = S_REFUND;
          w_nick_nx  = r_credit;
          w_cnt_nx   = '0;
        end
      end else if (r_pend[c_ITEM1]) begin
        w_clr[c_ITEM1] = 1'b1;
        if (r_credit == 2'd3) begin
          w_cmd_nx[c_ITEM1] = 1'b1;
          w_credit_nx       = 2'd0;
          w_state_nx        = S_DISP;
          w_cnt_nx          = CW'(DISP_CYCLES);
          w_sel2_nx         = 1'b0;
        end else begin
          w_deny_nx = 1'b1;
        end
      end else if (r_pend[c_ITEM2]) begin
        w_clr[c_ITEM2] = 1'b1;
        if (r_credit >= 2'd2) begin
          w_cmd_nx[c_ITEM2] = 1'b1;
          w_credit_nx       = r_credit - 2'd2;
          w_state_nx        = S_DISP;
          w_cnt_nx          = CW'(DISP_CYCLES);
          w_sel2_nx         = 1'b1;
        end else begin
          w_deny_nx = 1'b1;
        end
      end else if (r_pend[c_DIME]) begin
        w_clr[c_DIME] = 1'b1;
        if (r_credit <= 2'd1) begin
          w_cmd_nx[c_DIME] = 1'b1;
          w_credit_nx      = r_credit + 2'd2;
        end else begin
          w_rej_nx = 1'b1;
        end
      end else if (r_pend[c_NICK]) begin
        w_clr[c_NICK] = 1'b1;
        if (r_credit <= 2'd2) begin
          w_cmd_nx[c_NICK] = 1'b1;
          w_credit_nx      = r_credit + 2'd1;
        end else begin
          w_rej_nx = 1'b1;
        end
      end
    end

    // A fresh rise on the granted edge re-arms the request.
    w_pend_nx = (r_pend & ~w_clr) | w_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_nick   <= 2'd0;
      r_credit <= 2'd0;
      r_sel2   <= 1'b0;
      r_prev   <= '0;
      r_pend   <= '0;
      r_cmd    <= '0;
      r_chg    <= 1'b0;
      r_rej    <= 1'b0;
      r_deny   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_nick   <= w_nick_nx;
      r_credit <= w_credit_nx;
      r_sel2   <= w_sel2_nx;
      r_prev   <= w_in;
      r_pend   <= w_pend_nx;
      r_cmd    <= w_cmd_nx;
      r_chg    <= w_chg_nx;
      r_rej    <= w_rej_nx;
      r_deny   <= w_deny_nx;
    end
  end

  assign push_pulse    = r_cmd[c_PUSH];
  assign item1_pulse   = r_cmd[c_ITEM1];
  assign item2_pulse   = r_cmd[c_ITEM2];
  assign d_pulse       = r_cmd[c_DIME];
  assign n_pulse       = r_cmd[c_NICK];
  assign credit        = r_credit;
  assign dispense1     = (r_state == S_DISP) && !r_sel2;
  assign dispense2     = (r_state == S_DISP) &&  r_sel2;
  assign change_nickel = r_chg;
  assign coin_rej      = r_rej;
  assign item_deny     = r_deny;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vend_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_sched
// Purpose  : Self-checking bench for vend_sched. A timeline-level reference
//            model predicts every cycle's output vector and queues it; a
//            monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_sched;

  localparam int D = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic n_in = 1'b0, d_in = 1'b0, item1_req = 1'b0, item2_req = 1'b0, push_req = 1'b0;
  logic n_pulse, d_pulse, item1_pulse, item2_pulse, push_pulse;
  logic [1:0] credit;
  logic dispense1, dispense2, change_nickel, coin_rej, item_deny, busy;

  always #5 clk = ~clk;

  vend_sched #(.DISP_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst),
    .n_in(n_in), .d_in(d_in), .item1_req(item1_req), .item2_req(item2_req),
    .push_req(push_req),
    .n_pulse(n_pulse), .d_pulse(d_pulse), .item1_pulse(item1_pulse),
    .item2_pulse(item2_pulse), .push_pulse(push_pulse),
    .credit(credit), .dispense1(dispense1), .dispense2(dispense2),
    .change_nickel(change_nickel), .coin_rej(coin_rej), .item_deny(item_deny),
    .busy(busy)
  );

  // ---------------------------------------------------------------- model
  // Vector order: n d i1 i2 push credit[1:0] disp1 disp2 chg rej deny busy
  logic [12:0] exp_q[$];

  int e = 0;                // index of the cycle that starts at this edge
  logic [4:0] m_prev, m_pend, m_in;
  int m_credit, free_edge, busy_end;
  int disp_start, disp_end, disp_item;
  int ch_start, ch_cnt;
  logic xn, xd, xi1, xi2, xp, xchg, xrej, xdeny, xd1, xd2, xbusy;

  always @(posedge clk) begin
    m_in = {push_req, item1_req, item2_req, d_in, n_in};
    {xn, xd, xi1, xi2, xp, xchg, xrej, xdeny, xd1, xd2, xbusy} = '0;
    if (rst) begin
      m_prev = '0; m_pend = '0; m_credit = 0; free_edge = 0; busy_end = 0;
      disp_start = 0; disp_end = 0; disp_item = 1; ch_start = 0; ch_cnt = 0;
    end else begin
      if (e >= free_edge && m_pend != 5'd0) begin
        free_edge = e + 1;
        if (m_pend[4]) begin
          m_pend[4] = 1'b0; xp = 1'b1;
          if (m_credit > 0) begin
            ch_start  = e + 1;
            ch_cnt    = m_credit;
            busy_end  = e + m_credit * (G + 1) + 1;
            free_edge = busy_end + 1;
          end
          m_credit = 0;
        end else if (m_pend[3]) begin
          m_pend[3] = 1'b0;
          if (m_credit == 3) begin
            xi1 = 1'b1; m_credit = 0;
            disp_start = e; disp_end = e + D; disp_item = 1;
            busy_end = e + D; free_edge = e + D;
          end else xdeny = 1'b1;
        end else if (m_pend[2]) begin
          m_pend[2] = 1'b0;
          if (m_credit >= 2) begin
            xi2 = 1'b1; m_credit = m_credit - 2;
            disp_start = e; disp_end = e + D; disp_item = 2;
            busy_end = e + D; free_edge = e + D;
          end else xdeny = 1'b1;
        end else if (m_pend[1]) begin
          m_pend[1] = 1'b0;
          if (m_credit <= 1) begin xd = 1'b1; m_credit = m_credit + 2; end
          else xrej = 1'b1;
        end else begin
          m_pend[0] = 1'b0;
          if (m_credit <= 2) begin xn = 1'b1; m_credit = m_credit + 1; end
          else xrej = 1'b1;
        end
      end
      m_pend = m_pend | (m_in & ~m_prev);
      m_prev = m_in;
      xd1   = (e >= disp_start && e < disp_end && disp_item == 1);
      xd2   = (e >= disp_start && e < disp_end && disp_item == 2);
      xchg  = (ch_cnt > 0 && e >= ch_start && ((e - ch_start) % (G + 1)) == 0
               && ((e - ch_start) / (G + 1)) < ch_cnt);
      xbusy = (e < busy_end);
    end
    exp_q.push_back({xn, xd, xi1, xi2, xp, 2'(m_credit), xd1, xd2, xchg, xrej, xdeny, xbusy});
    e++;
  end

  // -------------------------------------------------------------- monitor
  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;
  int mcyc  = 0;
  logic [12:0] got, want;

  always @(negedge clk) begin
    if (!done) begin
      got = {n_pulse, d_pulse, item1_pulse, item2_pulse, push_pulse, credit,
             dispense1, dispense2, change_nickel, coin_rej, item_deny, busy};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL outputs cyc=%0d: no expected entry queued, got %b", mcyc, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL outputs cyc=%0d: got %b expected %b (n d i1 i2 p cr1 cr0 d1 d2 chg rej deny busy)",
                   mcyc, got, want);
        end
      end
      mcyc++;
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic drive(input logic [4:0] v, input int n);
    {push_req, item1_req, item2_req, d_in, n_in} = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [4:0] lv;
    @(negedge clk);
    drive(5'b00000, 3);
    rst = 1'b0;
    drive(5'b00000, 2);
    // N, D, N -> credit 1, 3, then reject
    drive(5'b00001, 2); drive(5'b00000, 1);
    drive(5'b00010, 2); drive(5'b00000, 1);
    drive(5'b00001, 2); drive(5'b00000, 2);
    // item1 at credit 3 -> dispense1
    drive(5'b01000, 2); drive(5'b00000, 8);
    // back to credit 3, item2, then item1 during dispense -> deny after
    drive(5'b00001, 2); drive(5'b00000, 1);
    drive(5'b00010, 2); drive(5'b00000, 1);
    drive(5'b00100, 2);
    drive(5'b01000, 2); drive(5'b00000, 6);
    // credit 2, push -> refund of 2 nickels
    drive(5'b00001, 2); drive(5'b00000, 1);
    drive(5'b10000, 2); drive(5'b00000, 12);
    // simultaneous push, dime, nickel at credit 0
    drive(5'b10011, 2); drive(5'b00000, 6);
    // credit 3, push, reset after first change pulse, inputs held high
    drive(5'b10000, 3);
    rst = 1'b1;
    drive(5'b10001, 2);
    rst = 1'b0;
    drive(5'b10001, 4);
    drive(5'b00000, 4);
    // random phase
    lv = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) lv[b] = ~lv[b];
      rst = ($urandom_range(0, 299) == 0);
      drive(lv, 1);
    end
    rst = 1'b0;
    drive(5'b00000, 20);
    done = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
